// File: rtl/branch_predictor_if.sv
// Fetch/resolve bus of the branch predictor.
// Handshake: fetch_valid and resolve_valid are single-cycle qualifiers with no
// back-pressure (the predictor always accepts). pred_valid qualifies
// pred_taken/pred_target one cycle after the request; mispredict qualifies
// redirect_pc one cycle after the resolve.
interface branch_predictor_if;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        resolve_pred_taken;
  logic [31:0] resolve_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  // Fetch/execute side driving requests into the predictor.
  modport master (
    output fetch_valid, fetch_pc,
    output resolve_valid, resolve_pc, resolve_taken, resolve_target,
    output resolve_pred_taken, resolve_pred_target,
    input  pred_valid, pred_taken, pred_target,
    input  mispredict, redirect_pc, branch_count, mispredict_count
  );

  // The predictor itself.
  modport slave (
    input  fetch_valid, fetch_pc,
    input  resolve_valid, resolve_pc, resolve_taken, resolve_target,
    input  resolve_pred_taken, resolve_pred_target,
    output pred_valid, pred_taken, pred_target,
    output mispredict, redirect_pc, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters. One lookup and one
// training update per cycle; lookups see the table as it was before the
// update written on the same edge (read-before-write).
module branch_predictor #(
  parameter int ENTRIES = 16
) (
  input logic              clk,
  input logic              rst,
  branch_predictor_if.slave bp
);
  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // BTB storage
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  // Registered prediction / redirect / counters
  logic        pred_valid_q, pred_valid_d;
  logic        pred_taken_q, pred_taken_d;
  logic [31:0] pred_target_q, pred_target_d;
  logic        mispredict_q, mispredict_d;
  logic [31:0] redirect_q, redirect_d;
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // Lookup side decode
  logic [IDX-1:0]   f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;
  logic             f_taken;
  logic [31:0]      f_target;

  // Update side decode
  logic [IDX-1:0]   r_idx;
  logic [TAG_W-1:0] r_tag;
  logic             r_hit;
  logic [1:0]       r_ctr_upd;
  logic [31:0]      r_expected_next;
  logic             r_mp;

  assign f_idx = bp.fetch_pc[IDX+1:2];
  assign f_tag = bp.fetch_pc[31:IDX+2];
  assign r_idx = bp.resolve_pc[IDX+1:2];
  assign r_tag = bp.resolve_pc[31:IDX+2];

  // Lookup: hit/direction/target from the current (pre-update) table contents.
  always_comb begin
    f_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    f_taken  = f_hit && ctr_q[f_idx][1];
    f_target = f_taken ? target_q[f_idx] : (bp.fetch_pc + 32'd4);
  end

  // Training decode: hit check, saturating counter step, mispredict check.
  always_comb begin
    r_hit     = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    r_ctr_upd = ctr_q[r_idx];
    if (bp.resolve_taken) begin
      if (ctr_q[r_idx] != 2'b11) r_ctr_upd = ctr_q[r_idx] + 2'd1;
    end else begin
      if (ctr_q[r_idx] != 2'b00) r_ctr_upd = ctr_q[r_idx] - 2'd1;
    end
    r_expected_next = bp.resolve_taken ? bp.resolve_target : (bp.resolve_pc + 32'd4);
    r_mp = (bp.resolve_taken != bp.resolve_pred_taken) ||
           (r_expected_next != bp.resolve_pred_target);
  end

  // Next-state for prediction, redirect and statistics registers.
  always_comb begin
    pred_valid_d  = bp.fetch_valid;
    pred_taken_d  = pred_taken_q;
    pred_target_d = pred_target_q;
    if (bp.fetch_valid) begin
      pred_taken_d  = f_taken;
      pred_target_d = f_target;
    end

    mispredict_d  = 1'b0;
    redirect_d    = redirect_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (bp.resolve_valid) begin
      mispredict_d = r_mp;
      redirect_d   = r_expected_next;
      if (branch_cnt_q != CNT_MAX) branch_cnt_d = branch_cnt_q + 32'd1;
      if (r_mp && (mispred_cnt_q != CNT_MAX)) mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  // BTB write port: train on hit, allocate on taken miss, ignore not-taken miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (bp.resolve_valid) begin
      if (r_hit) begin
        ctr_q[r_idx] <= r_ctr_upd;
        if (bp.resolve_taken) target_q[r_idx] <= bp.resolve_target;
      end else if (bp.resolve_taken) begin
        valid_q[r_idx]  <= 1'b1;
        tag_q[r_idx]    <= r_tag;
        target_q[r_idx] <= bp.resolve_target;
        ctr_q[r_idx]    <= 2'b10;
      end
    end
  end

  // Output and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      mispredict_q  <= 1'b0;
      redirect_q    <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      mispredict_q  <= mispredict_d;
      redirect_q    <= redirect_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bp.pred_valid       = pred_valid_q;
  assign bp.pred_taken       = pred_taken_q;
  assign bp.pred_target      = pred_target_q;
  assign bp.mispredict       = mispredict_q;
  assign bp.redirect_pc      = redirect_q;
  assign bp.branch_count     = branch_cnt_q;
  assign bp.mispredict_count = mispred_cnt_q;
endmodule
